// File: rtl/msgpass_rd_addr_gen.sv
// Read-address sequencer for message-pass buffer port A.
// Walks a latched [start, end] address window (wrapping at BUFF_DEPTH-1),
// holds the address while the memShare scheduler reports a data-reuse
// conflict, and flags a sticky stall error after STALL_LIMIT consecutive
// conflict cycles. All outputs are registered.
module msgpass_rd_addr_gen #(
  parameter int ADDR_WIDTH  = 3,
  parameter int BUFF_DEPTH  = 8,
  parameter int DRC_NUM     = 2,
  parameter int STALL_LIMIT = 4
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  buffer_read_begin_i,
  input  logic                  buffer_read_end_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] end_addr_i,
  input  logic [DRC_NUM-1:0]    is_drc_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  rd_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  stall_err_o
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUFF_DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] end_win_q, end_win_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  stall_err_q, stall_err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic begin_accept;
  logic conflict;

  // A begin that arrives together with end is treated as cancelled.
  assign begin_accept = buffer_read_begin_i && !buffer_read_end_i;
  assign conflict     = |is_drc_i;

  // State register and all registered outputs, async active-low reset.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      end_win_q   <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stall_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      end_win_q   <= end_win_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stall_err_q <= stall_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic; abort (end) outranks both conflict hold and advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (begin_accept) state_d = RUN;
      end
      RUN: begin
        if (buffer_read_end_i)                    state_d = IDLE;
        else if (!conflict && addr_q == end_win_q) state_d = WAIT_END;
      end
      WAIT_END: begin
        if (buffer_read_end_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; everything holds unless changed below.
  always_comb begin
    addr_d      = addr_q;
    end_win_d   = end_win_q;
    rd_en_d     = rd_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    stall_err_d = stall_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (begin_accept) begin
          end_win_d   = end_addr_i;
          addr_d      = start_addr_i;
          rd_en_d     = 1'b1;
          busy_d      = 1'b1;
          stall_err_d = 1'b0;
          cnt_d       = '0;
        end
      end
      RUN: begin
        if (buffer_read_end_i) begin
          rd_en_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (conflict) begin
          // Hold the address; count consecutive conflicts, saturating.
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) stall_err_d = 1'b1;
        end else begin
          cnt_d = '0;
          if (addr_q == end_win_q) rd_en_d = 1'b0;
          else if (addr_q == LAST_ADDR) addr_d = '0;
          else addr_d = addr_q + 1'b1;
        end
      end
      WAIT_END: begin
        if (buffer_read_end_i) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign addr_o      = addr_q;
  assign rd_en_o     = rd_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign stall_err_o = stall_err_q;

`ifndef SYNTHESIS
  // Window bounds outside the buffer have no defined behaviour.
  a_window_in_range: assert property (
    @(posedge sys_clk) disable iff (!rstn)
    (state_q == IDLE && begin_accept) |->
      (32'(start_addr_i) < BUFF_DEPTH && 32'(end_addr_i) < BUFF_DEPTH)
  ) else $error("window address out of range: start=%0d end=%0d",
                start_addr_i, end_addr_i);
`endif

endmodule

// File: tb/tb_msgpass_rd_addr_gen.sv
// Directed, table-driven bench for msgpass_rd_addr_gen.
module tb_msgpass_rd_addr_gen;

  logic       sys_clk;
  logic       rstn;
  logic       begin_i;
  logic       end_i;
  logic [2:0] start_addr;
  logic [2:0] end_addr;
  logic [1:0] is_drc;
  logic [2:0] addr_o;
  logic       rd_en_o;
  logic       busy_o;
  logic       done_o;
  logic       stall_err_o;

  int errors = 0;
  int checks = 0;

  msgpass_rd_addr_gen #(
    .ADDR_WIDTH (3),
    .BUFF_DEPTH (8),
    .DRC_NUM    (2),
    .STALL_LIMIT(4)
  ) dut (
    .sys_clk            (sys_clk),
    .rstn               (rstn),
    .buffer_read_begin_i(begin_i),
    .buffer_read_end_i  (end_i),
    .start_addr_i       (start_addr),
    .end_addr_i         (end_addr),
    .is_drc_i           (is_drc),
    .addr_o             (addr_o),
    .rd_en_o            (rd_en_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .stall_err_o        (stall_err_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       b;
    logic       e;
    logic [2:0] s;
    logic [2:0] ea;
    logic [1:0] drc;
    logic [2:0] x_addr;
    logic       x_rd;
    logic       x_busy;
    logic       x_done;
    logic       x_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic b, input logic e, input logic [2:0] s,
                   input logic [2:0] ea, input logic [1:0] drc,
                   input logic [2:0] x_addr, input logic x_rd,
                   input logic x_busy, input logic x_done, input logic x_stall);
    vec_t r;
    r.b = b; r.e = e; r.s = s; r.ea = ea; r.drc = drc;
    r.x_addr = x_addr; r.x_rd = x_rd; r.x_busy = x_busy;
    r.x_done = x_done; r.x_stall = x_stall;
    vecs.push_back(r);
  endtask

  // Outputs packed as {addr, rd_en, busy, done, stall_err}.
  function automatic logic [6:0] outs();
    return {addr_o, rd_en_o, busy_o, done_o, stall_err_o};
  endfunction

  task automatic check(input string name, input logic [6:0] act,
                       input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {addr,rd,busy,done,stall}=%b_%b%b%b%b, want %b_%b%b%b%b",
               name, act[6:4], act[3], act[2], act[1], act[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic e, input logic [2:0] s,
                       input logic [2:0] ea, input logic [1:0] drc);
    begin_i = b; end_i = e; start_addr = s; end_addr = ea; is_drc = drc;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    rstn = 1'b0;

    // End alone in IDLE is ignored
    v(0,1,0,0,0, 0,0,0,0,0);
    // Window 0..4: five reads, WAIT_END, then end -> done
    v(1,0,0,4,0, 0,1,1,0,0);
    v(0,0,0,0,0, 1,1,1,0,0);
    v(0,0,0,0,0, 2,1,1,0,0);
    v(0,0,0,0,0, 3,1,1,0,0);
    v(0,0,0,0,0, 4,1,1,0,0);
    v(0,0,0,0,0, 4,0,1,0,0);
    v(0,0,0,0,0, 4,0,1,0,0);
    v(0,1,0,0,0, 4,0,0,1,0);
    v(0,0,0,0,0, 4,0,0,0,0);
    // Window 1..3 with two conflict cycles at addr 2
    v(1,0,1,3,0, 1,1,1,0,0);
    v(0,0,0,0,0, 2,1,1,0,0);
    v(0,0,0,0,1, 2,1,1,0,0);
    v(0,0,0,0,1, 2,1,1,0,0);
    v(0,0,0,0,0, 3,1,1,0,0);
    v(0,0,0,0,0, 3,0,1,0,0);
    v(0,1,0,0,0, 3,0,0,1,0);
    // Five conflict cycles at addr 0: stall error on the 4th, sticky
    v(1,0,0,1,0, 0,1,1,0,0);
    v(0,0,0,0,2, 0,1,1,0,0);
    v(0,0,0,0,2, 0,1,1,0,0);
    v(0,0,0,0,2, 0,1,1,0,0);
    v(0,0,0,0,2, 0,1,1,0,1);
    v(0,0,0,0,2, 0,1,1,0,1);
    v(0,0,0,0,0, 1,1,1,0,1);
    v(0,0,0,0,0, 1,0,1,0,1);
    v(0,1,0,0,0, 1,0,0,1,1);
    v(0,0,0,0,0, 1,0,0,0,1);
    // Wrapping window 6..1; the accepted begin clears stall error
    v(1,0,6,1,0, 6,1,1,0,0);
    v(0,0,0,0,0, 7,1,1,0,0);
    v(0,0,0,0,0, 0,1,1,0,0);
    v(0,0,0,0,0, 1,1,1,0,0);
    v(0,0,0,0,0, 1,0,1,0,0);
    v(0,1,0,0,0, 1,0,0,1,0);
    // Single-address window
    v(1,0,5,5,0, 5,1,1,0,0);
    v(0,0,0,0,0, 5,0,1,0,0);
    v(0,1,0,0,0, 5,0,0,1,0);
    // Abort at addr 2 with a conflict present: end wins
    v(1,0,0,4,0, 0,1,1,0,0);
    v(0,0,0,0,0, 1,1,1,0,0);
    v(0,0,0,0,0, 2,1,1,0,0);
    v(0,1,0,0,1, 2,0,0,1,0);
    v(0,0,0,0,0, 2,0,0,0,0);
    // Begin during RUN ignored; begin+end in IDLE ignored
    v(1,0,0,4,0, 0,1,1,0,0);
    v(1,0,5,5,0, 1,1,1,0,0);
    v(0,1,0,0,0, 1,0,0,1,0);
    v(1,1,3,3,0, 1,0,0,0,0);
    v(0,0,0,0,0, 1,0,0,0,0);

    // Reset state, checked without any clock edge dependence
    #12;
    check("reset_state", outs(), 7'b000_0000);
    rstn = 1'b1;
    tick();
    check("idle_after_reset", outs(), 7'b000_0000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].b, vecs[i].e, vecs[i].s, vecs[i].ea, vecs[i].drc);
      tick();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].x_addr, vecs[i].x_rd, vecs[i].x_busy,
             vecs[i].x_done, vecs[i].x_stall});
    end

    // Asynchronous reset mid-RUN at addr 3
    drive(1, 0, 0, 4, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    check("pre_reset_addr3", outs(), 7'b011_1100);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_clears", outs(), 7'b000_0000);
    #2 rstn = 1'b1;
    tick();
    check("stay_idle_1", outs(), 7'b000_0000);
    tick();
    check("stay_idle_2", outs(), 7'b000_0000);
    drive(1, 0, 2, 2, 0);
    tick();
    check("begin_after_reset", outs(), 7'b010_1100);
    drive(0, 0, 0, 0, 0);
    tick();
    check("wait_end_after_reset", outs(), 7'b010_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
